fp_align_shift_pipe: RTL

- Parametrised, fully pipelined right-shift alignment unit for the FP add/sub datapath.
- Shifts the smaller mantissa right by the exponent difference, one power-of-two level per stage (largest level first, then down to 1).
- Carries a sideband tag and generates a sticky bit for rounding.
- Sits between exponent-compare and the mantissa adder; replaces the fixed single-level combinational shift stages with one registered, stallable block.

---
 rtl/fp_align_shift_pipe.sv | 120 ++++++++++++
 1 files changed

// File: rtl/fp_align_shift_pipe.sv
// Pipelined logical right-shift alignment unit for the FP add/sub mantissa path.
// Optional sticky generation is enabled by defining FPALIGN_STICKY_EN.
module fp_align_shift_pipe #(
    parameter int unsigned W       = 32,
    parameter int unsigned SHIFT_W = 5,
    parameter int unsigned TAG_W   = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [W-1:0]       in_mant,
    input  logic [SHIFT_W-1:0] in_shift,
    input  logic [TAG_W-1:0]   in_tag,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [W-1:0]       out_mant,
    output logic               out_sticky,
    output logic [TAG_W-1:0]   out_tag
);

    logic w_adv;
    logic w_out_valid;

    // Single advance enable: the whole pipe moves or the whole pipe holds.
    assign w_adv    = !w_out_valid || out_ready;
    assign in_ready = w_adv;

    for (genvar gi = 0; gi < SHIFT_W; gi++) begin : g_stage
        localparam int unsigned K   = SHIFT_W - 1 - gi;
        localparam bit          Sat = (K >= 31) || ((32'd1 << K) >= W);
        localparam int unsigned Amt = Sat ? 0 : (32'd1 << K);

        logic             w_src_valid;
        logic [W-1:0]     w_src_mant;
        logic [K:0]       w_src_shift;
        logic [TAG_W-1:0] w_src_tag;
        logic [W-1:0]     w_shifted;

        logic             r_valid;
        logic [W-1:0]     r_mant;
        logic [TAG_W-1:0] r_tag;

        if (gi == 0) begin : g_src_in
            // Bubbles load zeros so idle stages stay deterministic.
            assign w_src_valid = in_valid;
            assign w_src_mant  = in_valid ? in_mant : '0;
            assign w_src_shift = in_valid ? in_shift : '0;
            assign w_src_tag   = in_valid ? in_tag : '0;
        end else begin : g_src_prev
            assign w_src_valid = g_stage[gi-1].r_valid;
            assign w_src_mant  = g_stage[gi-1].r_mant;
            assign w_src_shift = g_stage[gi-1].g_rem.r_rem;
            assign w_src_tag   = g_stage[gi-1].r_tag;
        end

        assign w_shifted = Sat ? '0 : (w_src_mant >> Amt);

        always_ff @(posedge clk) begin
            if (rst) begin
                r_valid <= 1'b0;
                r_mant  <= '0;
                r_tag   <= '0;
            end else if (w_adv) begin
                r_valid <= w_src_valid;
                r_mant  <= w_src_shift[K] ? w_shifted : w_src_mant;
                r_tag   <= w_src_tag;
            end
        end

        // Only the shift bits below this level are still needed downstream.
        if (K > 0) begin : g_rem
            logic [K-1:0] r_rem;

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_rem <= '0;
                end else if (w_adv) begin
                    r_rem <= w_src_shift[K-1:0];
                end
            end
        end

`ifdef FPALIGN_STICKY_EN
        localparam logic [W-1:0] LostMask = ~({W{1'b1}} << Amt);

        logic w_src_sticky;
        logic w_lost;
        logic r_sticky;

        if (gi == 0) begin : g_stk_in
            assign w_src_sticky = 1'b0;
        end else begin : g_stk_prev
            assign w_src_sticky = g_stage[gi-1].r_sticky;
        end

        assign w_lost = Sat ? (|w_src_mant) : (|(w_src_mant & LostMask));

        always_ff @(posedge clk) begin
            if (rst) begin
                r_sticky <= 1'b0;
            end else if (w_adv) begin
                r_sticky <= w_src_sticky | (w_src_shift[K] & w_lost);
            end
        end
`endif
    end

    assign w_out_valid = g_stage[SHIFT_W-1].r_valid;
    assign out_valid   = w_out_valid;
    assign out_mant    = g_stage[SHIFT_W-1].r_mant;
    assign out_tag     = g_stage[SHIFT_W-1].r_tag;

`ifdef FPALIGN_STICKY_EN
    assign out_sticky = g_stage[SHIFT_W-1].r_sticky;
`else
    assign out_sticky = 1'b0;
`endif

endmodule
